// File: rtl/instr_fetch_pkg.sv
// Shared pipeline types for the fetch stage: IF/ID register layout, fetch FSM states,
// and the default reset PC.
package rv32i_types;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

   typedef struct packed {
      logic        valid_s;
      logic [31:0] pc_s;
      logic [31:0] pc_next_s;
      logic [63:0] order_s;
   } if_id_stage_reg_t;

   typedef enum logic [1:0] {
      S_ISSUE,
      S_WAIT,
      S_HOLD,
      S_FLUSH
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns PC and retire order, keeps one imem read outstanding, honours move stalls.
// Optional fetch redirect (redirect_en/redirect_pc, S_FLUSH) is built when IF_REDIRECT_EN is defined.
module instr_fetch
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             move,
   output logic [31:0]      imem_addr,
   output logic [3:0]       imem_rmask,
   input  logic             imem_resp,
`ifdef IF_REDIRECT_EN
   input  logic             redirect_en,
   input  logic [31:0]      redirect_pc,
`endif
   output if_id_stage_reg_t if_id_reg
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q;
   logic [63:0]  order_q, order_d;
   logic [31:0]  pc_next;
   logic         valid;
   logic         deliver;

   assign pc_next = pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_ISSUE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         order_q <= 64'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= imem_addr;
         order_q <= order_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      order_d    = order_q;
      imem_addr  = addr_q;
      imem_rmask = 4'h0;
      valid      = 1'b0;
      deliver    = 1'b0;
      // S_ISSUE would otherwise request while reset is still held
      if (!rst) begin
         case (state_q)
            S_ISSUE: begin
               imem_rmask = 4'hf;
               imem_addr  = pc_q;
               state_d    = S_WAIT;
            end
            S_WAIT: begin
               if (imem_resp) begin
                  valid = 1'b1;
                  if (move) deliver = 1'b1;
                  else      state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               valid = 1'b1;
               if (move) begin
                  deliver = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_FLUSH: begin
               if (imem_resp) begin
                  imem_rmask = 4'hf;
                  imem_addr  = pc_q;
                  state_d    = S_WAIT;
               end
            end
            default: state_d = S_ISSUE;
         endcase

         if (deliver) begin
            order_d    = order_q + 64'd1;
            pc_d       = pc_next;
            imem_addr  = pc_next;
            imem_rmask = 4'hf;
         end
`ifdef IF_REDIRECT_EN
         // A redirect beats move; whatever was delivered this cycle is cancelled.
         if (redirect_en) begin
            pc_d    = redirect_pc;
            order_d = order_q;
            valid   = 1'b0;
            if (state_q == S_HOLD ||
                (imem_resp && (state_q == S_WAIT || state_q == S_FLUSH))) begin
               imem_rmask = 4'hf;
               imem_addr  = redirect_pc;
               state_d    = S_WAIT;
            end else if (state_q == S_WAIT) begin
               imem_rmask = 4'h0;
               imem_addr  = addr_q;
               state_d    = S_FLUSH;
            end else if (state_q == S_ISSUE) begin
               // the old-PC request still leaves this cycle and must be drained
               state_d = S_FLUSH;
            end
         end
`endif
      end
   end

   assign if_id_reg = '{valid_s:   valid,
                        pc_s:      pc_q,
                        pc_next_s: pc_next,
                        order_s:   order_q};

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (standard and near-wrap reset PC) share one memory model;
// an instruction-stream model predicts requests and deliveries every cycle.
module tb_instr_fetch;
   import rv32i_types::*;

   localparam logic [31:0] RPC  = 32'h1eceb000;
   localparam logic [31:0] RPC2 = 32'hfffffffc;
`ifdef IF_REDIRECT_EN
   localparam bit HAS_RED = 1'b1;
`else
   localparam bit HAS_RED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic move = 1'b0;
   logic inject = 1'b0;
   logic redirect_en = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic imem_resp;
   logic [31:0] addr1, addr2;
   logic [3:0]  rmask1, rmask2;
   if_id_stage_reg_t ifid1, ifid2;

   int n_checks = 0;
   int n_err = 0;
   int lat = 1;
   logic mem_busy = 1'b0;
   int mem_cnt = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RPC)) u_dut (
      .clk(clk), .rst(rst), .move(move),
      .imem_addr(addr1), .imem_rmask(rmask1), .imem_resp(imem_resp),
`ifdef IF_REDIRECT_EN
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
`endif
      .if_id_reg(ifid1)
   );

   instr_fetch #(.RESET_PC(RPC2)) u_dut2 (
      .clk(clk), .rst(rst), .move(move),
      .imem_addr(addr2), .imem_rmask(rmask2), .imem_resp(imem_resp),
`ifdef IF_REDIRECT_EN
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
`endif
      .if_id_reg(ifid2)
   );

   // memory: answers each request lat cycles later, reset alongside the fetch stage
   assign imem_resp = (mem_busy && mem_cnt == 0) || inject;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_busy <= 1'b0;
         mem_cnt  <= 0;
      end else begin
         if (imem_resp) mem_busy <= 1'b0;
         if (rmask1 != 4'h0) begin
            mem_busy <= 1'b1;
            mem_cnt  <= lat - 1;
         end else if (mem_busy && !imem_resp) begin
            mem_cnt <= mem_cnt - 1;
         end
      end
   end

   // instruction-stream model
   logic        m_first, m_out, m_held, m_stale;
   logic [31:0] m_pc, m_addr, m_addr2, m_off2;
   logic [63:0] m_order;
   logic        red, rsp_live, e_valid, e_deliver, red_now, flush_issue, e_issue;
   logic [31:0] e_addr, e_addr2;

   always_comb begin
      red         = HAS_RED && redirect_en;
      rsp_live    = imem_resp && m_out && !m_stale;
      e_valid     = (rsp_live || m_held) && !red;
      e_deliver   = e_valid && move;
      red_now     = red && (m_held || (imem_resp && m_out));
      flush_issue = m_stale && imem_resp && m_out && !red;
      e_issue     = m_first || e_deliver || red_now || flush_issue;
      e_addr      = m_addr;
      e_addr2     = m_addr2;
      if (m_first || flush_issue) begin
         e_addr  = m_pc;
         e_addr2 = m_pc + m_off2;
      end else if (red_now) begin
         e_addr  = redirect_pc;
         e_addr2 = redirect_pc;
      end else if (e_deliver) begin
         e_addr  = m_pc + 32'd4;
         e_addr2 = m_pc + m_off2 + 32'd4;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_first <= 1'b1;
         m_out   <= 1'b0;
         m_held  <= 1'b0;
         m_stale <= 1'b0;
         m_pc    <= RPC;
         m_off2  <= RPC2 - RPC;
         m_addr  <= RPC;
         m_addr2 <= RPC2;
         m_order <= 64'd0;
      end else begin
         m_first <= 1'b0;
         m_out   <= e_issue ? 1'b1 : (imem_resp ? 1'b0 : m_out);
         m_held  <= red ? 1'b0 : ((rsp_live && !move) ? 1'b1 : (e_deliver ? 1'b0 : m_held));
         m_stale <= red ? (!red_now && (m_out || m_first)) : (flush_issue ? 1'b0 : m_stale);
         m_pc    <= red ? redirect_pc : (e_deliver ? m_pc + 32'd4 : m_pc);
         m_off2  <= red ? 32'd0 : m_off2;
         m_order <= e_deliver ? m_order + 64'd1 : m_order;
         m_addr  <= e_addr;
         m_addr2 <= e_addr2;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("rmask",     {60'd0, rmask1}, e_issue ? 64'hf : 64'h0);
         chk("addr",      {32'd0, addr1}, {32'd0, e_addr});
         chk("valid",     {63'd0, ifid1.valid_s}, {63'd0, e_valid});
         chk("pc_s",      {32'd0, ifid1.pc_s}, {32'd0, m_pc});
         chk("pc_next_s", {32'd0, ifid1.pc_next_s}, {32'd0, m_pc + 32'd4});
         chk("order_s",   ifid1.order_s, m_order);
         chk("rmask2",    {60'd0, rmask2}, e_issue ? 64'hf : 64'h0);
         chk("addr2",     {32'd0, addr2}, {32'd0, e_addr2});
         chk("pc_s2",     {32'd0, ifid2.pc_s}, {32'd0, m_pc + m_off2});
         chk("pc_next_s2",{32'd0, ifid2.pc_next_s}, {32'd0, m_pc + m_off2 + 32'd4});
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      move = 1'b1;
      lat  = 1;
      cyc(2);
      @(negedge clk);
      chk("rst_rmask", {60'd0, rmask1}, 64'h0);
      chk("rst_addr",  {32'd0, addr1}, 64'h1eceb000);
      chk("rst_valid", {63'd0, ifid1.valid_s}, 64'h0);
      chk("rst_pc",    {32'd0, ifid1.pc_s}, 64'h1eceb000);
      chk("rst_pcn",   {32'd0, ifid1.pc_next_s}, 64'h1eceb004);
      chk("rst_order", ifid1.order_s, 64'h0);
      chk("rst_pcn2",  {32'd0, ifid2.pc_next_s}, 64'h0);

      // back-to-back fetch with 1-cycle memory
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      chk("first_rmask", {60'd0, rmask1}, 64'hf);
      chk("first_addr",  {32'd0, addr1}, 64'h1eceb000);
      cyc(1);
      @(negedge clk);
      chk("resp0_valid", {63'd0, ifid1.valid_s}, 64'h1);
      chk("resp0_order", ifid1.order_s, 64'h0);
      chk("wrap_addr2",  {32'd0, addr2}, 64'h0);
      cyc(2);
      @(negedge clk);
      chk("order2",    ifid1.order_s, 64'h2);
      chk("pc2",       {32'd0, ifid1.pc_s}, 64'h1eceb008);
      chk("req3_addr", {32'd0, addr1}, 64'h1eceb00c);

      // stall with a response in hand
      cyc(2);
      move = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("hold_valid", {63'd0, ifid1.valid_s}, 64'h1);
      chk("hold_rmask", {60'd0, rmask1}, 64'h0);
      cyc(1);
      move = 1'b1;
      cyc(4);

      // slow memory, then a few stalls on top
      lat = 5;
      cyc(30);
      for (int i = 0; i < 20; i++) begin
         move = (i % 3) != 0;
         cyc(1);
      end
      move = 1'b1;
      cyc(3);

      // reset while a request is outstanding, stray response right after release
      rst = 1'b1;
      cyc(2);
      @(negedge clk);
      chk("midrst_rmask", {60'd0, rmask1}, 64'h0);
      chk("midrst_order", ifid1.order_s, 64'h0);
      cyc(1);
      rst = 1'b0;
      inject = 1'b1;
      @(negedge clk);
      chk("late_resp_valid", {63'd0, ifid1.valid_s}, 64'h0);
      chk("reissue_addr",    {32'd0, addr1}, 64'h1eceb000);
      cyc(1);
      inject = 1'b0;
      cyc(15);

`ifdef IF_REDIRECT_EN
      redirect_en = 1'b1;
      redirect_pc = 32'h1eceb100;
      cyc(1);
      redirect_en = 1'b0;
      cyc(8);
      @(negedge clk);
      chk("redir_valid", {63'd0, ifid1.valid_s}, 64'h1);
      chk("redir_pc",    {32'd0, ifid1.pc_s}, 64'h1eceb100);
      cyc(10);
`endif

      // mixed latency and stalls
      for (int i = 0; i < 150; i++) begin
         lat  = $urandom_range(1, 3);
         move = $urandom_range(0, 1) != 0;
         cyc(1);
      end
      move = 1'b1;
      cyc(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
